jtag_ir_decode: RTL and testbench
=================================

// Module: jtag_ir_decode
// PURPOSE
// - Instruction register, instruction decoder and data-register/TDO selection for the boundary-scan port.
// - Sits directly downstream of the TAP controller and consumes its clockir/shiftir/updateir/clockdr/shiftdr/select strobes.
// - Holds the bypass and IDCODE data registers locally; the boundary-scan cell chain is external and is selected here.
// PARAMETERS
// IR_W       4             instruction register width, >=2
// IDCODE_VAL 32'h10765093  IDCODE register contents; bit0 must be 1
// PORTS
// TCK        in   1     test clock; all state changes on the rising edge
// TRST       in   1     asynchronous active-high reset
// TDI        in   1     serial data in
// clockir    in   1     IR capture/shift enable, from TAP
// shiftir    in   1     IR shift (1) vs capture (0)
// updateir   in   1     IR update strobe
// clockdr    in   1     DR capture/shift enable, from TAP
// shiftdr    in   1     DR shift (1) vs capture (0)
// select     in   1     1 = IR path to TDO, 0 = DR path
// bsr_tdo    in   1     serial out of the external boundary-scan chain
// ir_out     out  IR_W  active (updated) instruction
// sel_bypass out  1     bypass DR selected
// sel_idcode out  1     IDCODE DR selected
// sel_bsr    out  1     boundary-scan chain selected (EXTEST or SAMPLE)
// mode_extest out 1     EXTEST active; drives boundary cells' mode
// TDO        out  1     registered serial out
// tdo_en     out  1     registered; 1 while a shift is in progress
// BEHAVIOUR
// - Opcodes: EXTEST=all-0, SAMPLE/PRELOAD=0..01, IDCODE=0..010, BYPASS=all-1; every other code decodes as BYPASS.
// - Exactly one of sel_bypass/sel_idcode/sel_bsr is 1 at all times; all are decoded combinationally from ir_out.
// - IR shift stage ir_sh[IR_W-1:0]:
//   - clockir & !shiftir: load the capture pattern {0..0,01}.
//   - clockir & shiftir: ir_sh <= {TDI, ir_sh[IR_W-1:1]} (LSB first).
// - Update: updateir => ir_out <= ir_sh, using the pre-edge value. If updateir and clockir are both high, both actions take effect, and the update uses the pre-shift value.
// - Bypass reg (1 bit): clockdr & sel_bypass & !shiftdr => 0; with shiftdr => TDI.
// - IDCODE reg (32 bit): clockdr & sel_idcode & !shiftdr => IDCODE_VAL; with shiftdr => {TDI, id[31:1]}.
// - Boundary chain capture/shift is external; this block only routes bsr_tdo.
// - TDO: every rising edge, TDO <= select ? ir_sh[0] : (DR LSB of the selected register, or bsr_tdo), using pre-edge values.
//   - Result: one TCK latency from register LSB to pin.
// - tdo_en: registered each rising edge from (shiftir | shiftdr).
// - Registers not enabled hold their value; no strobes means no state change.
// - Reset (async, TRST=1, at any time including mid-shift):
//   - ir_sh = {0..0,01}; ir_out = IDCODE opcode.
//   - bypass = 0; id = IDCODE_VAL; TDO = 0; tdo_en = 0.
//   - Outputs are valid immediately, without waiting for TCK.
// - No state depends on the TAP state encoding; only the strobes listed above are used.
// CONFIGURATION
// - JTAG_IDCODE_EN defined:
//   - The IDCODE register is present.
//   - The IDCODE opcode selects it.
//   - Reset instruction = IDCODE.
// - JTAG_IDCODE_EN undefined:
//   - No IDCODE register is built.
//   - The IDCODE opcode decodes as BYPASS; sel_idcode is tied to 0.
//   - Reset instruction = BYPASS (all-1); the reset value of ir_sh is unchanged.
// TESTING
// - TRST pulse without TCK -> ir_out=4'b0010, sel_idcode=1, TDO=0, tdo_en=0 (IDCODE_EN defined).
// - IR capture, then 4 shifts with TDI=1 -> TDO sequence 1,0,0,0 (one-cycle lag). Then updateir -> ir_out=4'b1111, sel_bypass=1.
// - IDCODE active: DR capture, then 32 shifts -> TDO emits 0x10765093 LSB first, starting the edge after the first shift.
// - Load opcode 4'b0101 -> sel_bypass=1. DR capture, then shift TDI=1,0,1 -> TDO=0,1,0,1 (bypass 0 first, one-bit delay).
// - Load 4'b0000 -> mode_extest=1, sel_bsr=1; DR shift routes bsr_tdo to TDO one cycle later.
// - TRST asserted after 2 of 4 IR shift bits -> ir_sh=0001, ir_out reset value. A subsequent updateir yields ir_out=0001 (SAMPLE).

Source files
------------

// File: rtl/jtag_ir_decode.sv
// Boundary-scan instruction register, opcode decode and DR/TDO routing behind the TAP controller.
// Define JTAG_IDCODE_EN to build the IDCODE data register; otherwise the IDCODE opcode decodes as BYPASS.
module jtag_ir_decode #(
    parameter int          IR_W       = 4,
    parameter logic [31:0] IDCODE_VAL = 32'h10765093
) (
    input  logic            TCK,
    input  logic            TRST,
    input  logic            TDI,
    input  logic            clockir,
    input  logic            shiftir,
    input  logic            updateir,
    input  logic            clockdr,
    input  logic            shiftdr,
    input  logic            select,
    input  logic            bsr_tdo,
    output logic [IR_W-1:0] ir_out,
    output logic            sel_bypass,
    output logic            sel_idcode,
    output logic            sel_bsr,
    output logic            mode_extest,
    output logic            TDO,
    output logic            tdo_en
);

    localparam logic [IR_W-1:0] OP_EXTEST  = '0;
    localparam logic [IR_W-1:0] OP_SAMPLE  = IR_W'(1);
    localparam logic [IR_W-1:0] OP_IDCODE  = IR_W'(2);
    localparam logic [IR_W-1:0] OP_BYPASS  = '1;
    localparam logic [IR_W-1:0] IR_CAPTURE = IR_W'(1);

`ifdef JTAG_IDCODE_EN
    localparam logic [IR_W-1:0] RST_INSTR = OP_IDCODE;
`else
    localparam logic [IR_W-1:0] RST_INSTR = OP_BYPASS;
`endif

    // Catch illegal parameterisations at elaboration time.
    if (IR_W < 2 || IDCODE_VAL[0] != 1'b1) begin : g_bad_param
        $error("jtag_ir_decode: IR_W must be >= 2 and IDCODE_VAL[0] must be 1");
    end

    logic [IR_W-1:0] ir_sh_q, ir_sh_d;
    logic [IR_W-1:0] ir_out_q, ir_out_d;
    logic            bypass_q, bypass_d;
    logic            tdo_q, tdo_d;
    logic            tdo_en_q, tdo_en_d;
    logic            dr_tdo;
    logic            is_extest, is_sample, is_idcode;

    always_comb begin
        ir_sh_d = ir_sh_q;
        if (clockir) begin
            ir_sh_d = shiftir ? {TDI, ir_sh_q[IR_W-1:1]} : IR_CAPTURE;
        end
    end

    // Update samples the pre-edge shift stage, so a coincident shift does not leak in.
    assign ir_out_d = updateir ? ir_sh_q : ir_out_q;

    assign is_extest = (ir_out_q == OP_EXTEST);
    assign is_sample = (ir_out_q == OP_SAMPLE);
`ifdef JTAG_IDCODE_EN
    assign is_idcode = (ir_out_q == OP_IDCODE);
`else
    assign is_idcode = 1'b0;
`endif

    // Any opcode not otherwise recognised falls through to BYPASS.
    assign sel_bsr     = is_extest | is_sample;
    assign sel_idcode  = is_idcode;
    assign sel_bypass  = ~(sel_bsr | sel_idcode);
    assign mode_extest = is_extest;

    always_comb begin
        bypass_d = bypass_q;
        if (clockdr && sel_bypass) begin
            bypass_d = shiftdr ? TDI : 1'b0;
        end
    end

`ifdef JTAG_IDCODE_EN
    logic [31:0] id_q, id_d;

    always_comb begin
        id_d = id_q;
        if (clockdr && sel_idcode) begin
            id_d = shiftdr ? {TDI, id_q[31:1]} : IDCODE_VAL;
        end
    end

    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST) begin
            id_q <= IDCODE_VAL;
        end else begin
            id_q <= id_d;
        end
    end

    always_comb begin
        dr_tdo = bypass_q;
        if (sel_bsr) begin
            dr_tdo = bsr_tdo;
        end else if (sel_idcode) begin
            dr_tdo = id_q[0];
        end
    end
`else
    always_comb begin
        dr_tdo = bypass_q;
        if (sel_bsr) begin
            dr_tdo = bsr_tdo;
        end
    end
`endif

    assign tdo_d    = select ? ir_sh_q[0] : dr_tdo;
    assign tdo_en_d = shiftir | shiftdr;

    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST) begin
            ir_sh_q  <= IR_CAPTURE;
            ir_out_q <= RST_INSTR;
            bypass_q <= 1'b0;
            tdo_q    <= 1'b0;
            tdo_en_q <= 1'b0;
        end else begin
            ir_sh_q  <= ir_sh_d;
            ir_out_q <= ir_out_d;
            bypass_q <= bypass_d;
            tdo_q    <= tdo_d;
            tdo_en_q <= tdo_en_d;
        end
    end

    assign ir_out = ir_out_q;
    assign TDO    = tdo_q;
    assign tdo_en = tdo_en_q;

endmodule

// File: tb/tb_jtag_ir_decode.sv
// Directed bench for jtag_ir_decode: IR capture/shift/update, decode, bypass, IDCODE, EXTEST routing, async reset.
module tb_jtag_ir_decode;

    logic       TCK = 1'b0, TRST = 1'b0, TDI = 1'b0;
    logic       clockir = 1'b0, shiftir = 1'b0, updateir = 1'b0;
    logic       clockdr = 1'b0, shiftdr = 1'b0, select = 1'b0, bsr_tdo = 1'b0;
    logic [3:0] ir_out;
    logic       sel_bypass, sel_idcode, sel_bsr, mode_extest, TDO, tdo_en;
    int         nvec = 0;
    int         nerr = 0;

`ifdef JTAG_IDCODE_EN
    localparam logic [3:0] RST_IR = 4'b0010;
    localparam logic       RST_ID = 1'b1;
`else
    localparam logic [3:0] RST_IR = 4'b1111;
    localparam logic       RST_ID = 1'b0;
`endif

    jtag_ir_decode dut (
        .TCK(TCK), .TRST(TRST), .TDI(TDI),
        .clockir(clockir), .shiftir(shiftir), .updateir(updateir),
        .clockdr(clockdr), .shiftdr(shiftdr), .select(select), .bsr_tdo(bsr_tdo),
        .ir_out(ir_out), .sel_bypass(sel_bypass), .sel_idcode(sel_idcode),
        .sel_bsr(sel_bsr), .mode_extest(mode_extest), .TDO(TDO), .tdo_en(tdo_en)
    );

    always #5 TCK = ~TCK;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge TCK);
        #1;
    endtask

    task automatic load_ir(input logic [3:0] op);
        select = 1'b1; clockir = 1'b1; shiftir = 1'b0;
        tick();
        shiftir = 1'b1;
        for (int i = 0; i < 4; i++) begin
            TDI = op[i];
            tick();
        end
        clockir = 1'b0; shiftir = 1'b0; updateir = 1'b1;
        tick();
        updateir = 1'b0;
    endtask

    task automatic test_reset();
        TRST = 1'b1;
        #2;
        nvec++; if (ir_out !== RST_IR) begin nerr++; $display("FAIL reset_ir_out got=%b exp=%b", ir_out, RST_IR); end
        nvec++; if (sel_idcode !== RST_ID || sel_bypass !== ~RST_ID || sel_bsr !== 1'b0) begin
            nerr++; $display("FAIL reset_sel got=%b%b%b exp=%b%b0", sel_idcode, sel_bypass, sel_bsr, RST_ID, ~RST_ID);
        end
        nvec++; if (TDO !== 1'b0 || tdo_en !== 1'b0) begin nerr++; $display("FAIL reset_tdo got=%b/%b exp=0/0", TDO, tdo_en); end
        tick();
        TRST = 1'b0;
    endtask

    task automatic test_ir_shift();
        logic [3:0] exp_tdo;
        exp_tdo = 4'b0001;
        select = 1'b1; clockir = 1'b1; shiftir = 1'b0;
        tick();
        nvec++; if (tdo_en !== 1'b0) begin nerr++; $display("FAIL ir_capture_en got=%b exp=0", tdo_en); end
        shiftir = 1'b1; TDI = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            nvec++; if (TDO !== exp_tdo[i]) begin nerr++; $display("FAIL ir_shift_tdo[%0d] got=%b exp=%b", i, TDO, exp_tdo[i]); end
            nvec++; if (tdo_en !== 1'b1) begin nerr++; $display("FAIL ir_shift_en[%0d] got=%b exp=1", i, tdo_en); end
        end
        clockir = 1'b0; shiftir = 1'b0; updateir = 1'b1;
        tick();
        updateir = 1'b0;
        nvec++; if (ir_out !== 4'b1111) begin nerr++; $display("FAIL ir_update got=%b exp=1111", ir_out); end
        nvec++; if (sel_bypass !== 1'b1 || sel_idcode !== 1'b0 || sel_bsr !== 1'b0) begin
            nerr++; $display("FAIL ir_update_sel got=%b%b%b exp=100", sel_bypass, sel_idcode, sel_bsr);
        end
    endtask

    task automatic test_idcode();
        logic [31:0] exp_id;
        exp_id = 32'h10765093;
        load_ir(4'b0010);
        select = 1'b0; clockdr = 1'b1; shiftdr = 1'b0;
`ifdef JTAG_IDCODE_EN
        nvec++; if (sel_idcode !== 1'b1 || sel_bypass !== 1'b0 || sel_bsr !== 1'b0) begin
            nerr++; $display("FAIL idcode_sel got=%b%b%b exp=100", sel_idcode, sel_bypass, sel_bsr);
        end
        tick();
        shiftdr = 1'b1; TDI = 1'b0;
        for (int i = 0; i < 32; i++) begin
            tick();
            nvec++; if (TDO !== exp_id[i]) begin nerr++; $display("FAIL idcode_bit[%0d] got=%b exp=%b", i, TDO, exp_id[i]); end
        end
`else
        nvec++; if (sel_idcode !== 1'b0 || sel_bypass !== 1'b1 || sel_bsr !== 1'b0) begin
            nerr++; $display("FAIL idcode_sel got=%b%b%b exp=010", sel_idcode, sel_bypass, sel_bsr);
        end
        tick();
        shiftdr = 1'b1; TDI = 1'b1;
        tick();
        nvec++; if (TDO !== 1'b0) begin nerr++; $display("FAIL idcode_as_bypass0 got=%b exp=0", TDO); end
        tick();
        nvec++; if (TDO !== 1'b1) begin nerr++; $display("FAIL idcode_as_bypass1 got=%b exp=1 (id=%h)", TDO, exp_id); end
`endif
        clockdr = 1'b0; shiftdr = 1'b0;
    endtask

    task automatic test_bypass();
        logic [2:0] tdi_seq;
        logic [2:0] exp_tdo;
        tdi_seq = 3'b101;
        exp_tdo = 3'b010;
        load_ir(4'b0101);
        nvec++; if (sel_bypass !== 1'b1 || sel_idcode !== 1'b0 || sel_bsr !== 1'b0) begin
            nerr++; $display("FAIL bypass_sel got=%b%b%b exp=100", sel_bypass, sel_idcode, sel_bsr);
        end
        select = 1'b0; clockdr = 1'b1; shiftdr = 1'b0;
        tick();
        shiftdr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            TDI = tdi_seq[i];
            tick();
            nvec++; if (TDO !== exp_tdo[i]) begin nerr++; $display("FAIL bypass_tdo[%0d] got=%b exp=%b", i, TDO, exp_tdo[i]); end
        end
        clockdr = 1'b0; shiftdr = 1'b0;
        tick();
        nvec++; if (TDO !== 1'b1) begin nerr++; $display("FAIL bypass_tdo[3] got=%b exp=1", TDO); end
    endtask

    task automatic test_extest();
        logic [3:0] bsr_seq;
        bsr_seq = 4'b1101;
        load_ir(4'b0000);
        nvec++; if (mode_extest !== 1'b1 || sel_bsr !== 1'b1 || sel_bypass !== 1'b0 || sel_idcode !== 1'b0) begin
            nerr++; $display("FAIL extest_sel got=%b%b%b%b exp=1100", mode_extest, sel_bsr, sel_bypass, sel_idcode);
        end
        select = 1'b0; clockdr = 1'b1; shiftdr = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bsr_tdo = bsr_seq[i];
            tick();
            nvec++; if (TDO !== bsr_seq[i]) begin nerr++; $display("FAIL extest_tdo[%0d] got=%b exp=%b", i, TDO, bsr_seq[i]); end
        end
        clockdr = 1'b0; shiftdr = 1'b0; bsr_tdo = 1'b0;
    endtask

    task automatic test_trst_midshift();
        select = 1'b1; clockir = 1'b1; shiftir = 1'b0;
        tick();
        shiftir = 1'b1; TDI = 1'b1;
        tick();
        TDI = 1'b0;
        tick();
        TRST = 1'b1;
        #1;
        nvec++; if (ir_out !== RST_IR) begin nerr++; $display("FAIL trst_ir_out got=%b exp=%b", ir_out, RST_IR); end
        nvec++; if (TDO !== 1'b0 || tdo_en !== 1'b0) begin nerr++; $display("FAIL trst_tdo got=%b/%b exp=0/0", TDO, tdo_en); end
        clockir = 1'b0; shiftir = 1'b0;
        #1;
        TRST = 1'b0;
        updateir = 1'b1;
        tick();
        updateir = 1'b0;
        nvec++; if (ir_out !== 4'b0001) begin nerr++; $display("FAIL trst_update got=%b exp=0001", ir_out); end
        nvec++; if (sel_bsr !== 1'b1 || mode_extest !== 1'b0 || sel_bypass !== 1'b0) begin
            nerr++; $display("FAIL sample_sel got=%b%b%b exp=100", sel_bsr, mode_extest, sel_bypass);
        end
        tick();
        nvec++; if (TDO !== 1'b1 || tdo_en !== 1'b0) begin nerr++; $display("FAIL trst_ir_lsb got=%b/%b exp=1/0", TDO, tdo_en); end
    endtask

    task automatic test_update_shift();
        select = 1'b1; clockir = 1'b1; shiftir = 1'b1; updateir = 1'b1; TDI = 1'b1;
        tick();
        nvec++; if (ir_out !== 4'b0001) begin nerr++; $display("FAIL upd_shift_ir_out got=%b exp=0001", ir_out); end
        nvec++; if (TDO !== 1'b1) begin nerr++; $display("FAIL upd_shift_tdo got=%b exp=1", TDO); end
        clockir = 1'b0; shiftir = 1'b0;
        tick();
        updateir = 1'b0;
        nvec++; if (ir_out !== 4'b1000 || sel_bypass !== 1'b1) begin
            nerr++; $display("FAIL upd_after_shift got=%b/%b exp=1000/1", ir_out, sel_bypass);
        end
    endtask

    task automatic test_hold();
        repeat (3) tick();
        nvec++; if (ir_out !== 4'b1000) begin nerr++; $display("FAIL hold_ir_out got=%b exp=1000", ir_out); end
        nvec++; if (TDO !== 1'b0 || tdo_en !== 1'b0) begin nerr++; $display("FAIL hold_tdo got=%b/%b exp=0/0", TDO, tdo_en); end
    endtask

    initial begin
        test_reset();
        test_ir_shift();
        test_idcode();
        test_bypass();
        test_extest();
        test_trst_midshift();
        test_update_shift();
        test_hold();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
